// File: rtl/inst_loader_pkg.sv
`default_nettype none
// ============================================================================
// loader_pkg : end-of-program marker and loader FSM encoding | Rev 1.0
// ============================================================================
package loader_pkg;

  localparam logic [31:0] END_MARKER = 32'hffff_ffff;

  typedef enum logic [1:0] {
    LD_LOAD  = 2'd0,
    LD_DRAIN = 2'd1,
    LD_DONE  = 2'd2
  } ld_state_e;

endpackage
`default_nettype wire

// File: rtl/inst_loader_if.sv
`default_nettype none
// ============================================================================
// inst_loader_if : UART byte input, SRAM write port, status and CPU forward | Rev 1.0
// ============================================================================
interface inst_loader_if #(
  parameter int ADDR_WIDTH = 20
);

  logic [7:0]            rx_data;
  logic                  rx_changed;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_we;
  logic                  mem_ack;
  logic                  loaded;
  logic [ADDR_WIDTH-1:0] word_count;
  logic                  error;
  logic [7:0]            fwd_data;
  logic                  fwd_valid;

  // master = the loader itself, slave = receiver/SRAM/CPU side
  modport master (
    input  rx_data, rx_changed, mem_ack,
    output mem_addr, mem_wdata, mem_we, loaded, word_count, error, fwd_data, fwd_valid
  );

  modport slave (
    output rx_data, rx_changed, mem_ack,
    input  mem_addr, mem_wdata, mem_we, loaded, word_count, error, fwd_data, fwd_valid
  );

endinterface
`default_nettype wire

// File: rtl/inst_loader_byte_to_word.sv
`default_nettype none
// ============================================================================
// byte_to_word : big-endian byte-to-word assembler for the boot loader | Rev 1.0
// ============================================================================
module byte_to_word (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic [7:0]  byte_i,
  input  wire logic        strobe_i,
  output logic      [31:0] word_o,
  output logic             word_valid_o
);

  logic [1:0]  idx_q;
  logic [23:0] shift_q;

  // The fourth byte is merged combinationally so the word is usable in its arrival cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= 2'd0;
      shift_q <= 24'd0;
    end else if (strobe_i) begin
      idx_q   <= idx_q + 2'd1;
      shift_q <= {shift_q[15:0], byte_i};
    end
  end

  assign word_o       = {shift_q, byte_i};
  assign word_valid_o = strobe_i && (idx_q == 2'd3);

endmodule
`default_nettype wire

// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
// inst_loader : boot-time UART-to-SRAM program loader with post-load byte forward | Rev 1.0
// ============================================================================
module inst_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int MAX_WORDS  = 4096
) (
  input  wire logic         clk,
  input  wire logic         reset,
  inst_loader_if.master     bus
);

  localparam logic [ADDR_WIDTH-1:0] CAPACITY = ADDR_WIDTH'(MAX_WORDS);

  ld_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  loaded_q, loaded_d;
  logic                  error_q, error_d;
  logic [7:0]            fwd_data_q, fwd_data_d;
  logic                  fwd_valid_q, fwd_valid_d;

  logic [31:0] word;
  logic        word_valid;
  logic        write_pending;

  byte_to_word u_b2w (
    .clk          (clk),
    .reset        (reset),
    .byte_i       (bus.rx_data),
    .strobe_i     (bus.rx_changed && (state_q == LD_LOAD)),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  // A write being acked this very cycle no longer blocks a new word.
  assign write_pending = we_q && !bus.mem_ack;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    count_d     = count_q;
    loaded_d    = loaded_q;
    error_d     = error_q;
    fwd_data_d  = fwd_data_q;
    fwd_valid_d = 1'b0;

    if (we_q && bus.mem_ack) begin
      we_d = 1'b0;
    end

    case (state_q)
      LD_LOAD: begin
        if (word_valid) begin
          if (word == END_MARKER) begin
            if (write_pending) begin
              state_d = LD_DRAIN;
            end else begin
              state_d  = LD_DONE;
              loaded_d = 1'b1;
            end
          end else if ((count_q == CAPACITY) || write_pending) begin
            error_d = 1'b1;
          end else begin
            addr_d  = count_q;
            wdata_d = word;
            we_d    = 1'b1;
            count_d = count_q + ADDR_WIDTH'(1);
          end
        end
      end
      LD_DRAIN: begin
        if (bus.mem_ack) begin
          state_d  = LD_DONE;
          loaded_d = 1'b1;
        end
      end
      LD_DONE: begin
        if (bus.rx_changed) begin
          fwd_valid_d = 1'b1;
          fwd_data_d  = bus.rx_data;
        end
      end
      default: state_d = LD_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LD_LOAD;
      addr_q      <= '0;
      count_q     <= '0;
      wdata_q     <= 32'd0;
      we_q        <= 1'b0;
      loaded_q    <= 1'b0;
      error_q     <= 1'b0;
      fwd_data_q  <= 8'd0;
      fwd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      loaded_q    <= loaded_d;
      error_q     <= error_d;
      fwd_data_q  <= fwd_data_d;
      fwd_valid_q <= fwd_valid_d;
    end
  end

  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_we     = we_q;
  assign bus.loaded     = loaded_q;
  assign bus.word_count = count_q;
  assign bus.error      = error_q;
  assign bus.fwd_data   = fwd_data_q;
  assign bus.fwd_valid  = fwd_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// ============================================================================
// tb_inst_loader : self-checking bench for inst_loader (MAX_WORDS = 2) | Rev 1.0
// ============================================================================
module tb_inst_loader;

  localparam int AW  = 20;
  localparam int MAX = 2;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [31:0]   word;
    logic          exp_we;
    logic [AW-1:0] exp_count;
    logic          exp_error;
    logic          exp_loaded;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic auto_ack = 1'b0;
  int   ack_wait = 0;
  int   n_tests  = 0;
  int   n_fail   = 0;

  wr_t        exp_wr[$];
  logic [7:0] exp_fwd[$];
  vec_t       vecs[4];

  inst_loader_if #(.ADDR_WIDTH(AW)) bus ();

  inst_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_data    = b;
    bus.rx_changed = 1'b1;
    @(posedge clk); #1;
    bus.rx_changed = 1'b0;
    bus.rx_data    = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.mem_we && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout_mem_we", 32'(bus.mem_we), 32'd0);
  endtask

  // Acks a write one cycle after it appears when auto_ack is set.
  initial begin
    bus.mem_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (auto_ack) begin
        if (bus.mem_we && !bus.mem_ack) begin
          if (ack_wait >= 1) bus.mem_ack = 1'b1;
          else ack_wait++;
        end else begin
          bus.mem_ack = 1'b0;
          ack_wait    = 0;
        end
      end
    end
  end

  // Scoreboard and bus-stability monitor, sampled mid-cycle.
  initial begin
    wr_t           e;
    logic [7:0]    f;
    logic          prev_we  = 1'b0;
    logic          prev_ack = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [31:0]   prev_data = 32'd0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.mem_we && bus.mem_ack) begin
          if (exp_wr.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_write: got addr %0h data %0h required no write", bus.mem_addr, bus.mem_wdata);
          end else begin
            e = exp_wr.pop_front();
            check("write_addr", 32'(bus.mem_addr), 32'(e.addr));
            check("write_data", bus.mem_wdata, e.data);
          end
        end
        if (bus.fwd_valid) begin
          if (exp_fwd.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_fwd: got %0h required no pulse", bus.fwd_data);
          end else begin
            f = exp_fwd.pop_front();
            check("fwd_data_sb", 32'(bus.fwd_data), 32'(f));
          end
        end
        if (prev_we && !prev_ack && bus.mem_we) begin
          check("stable_addr", 32'(bus.mem_addr), 32'(prev_addr));
          check("stable_data", bus.mem_wdata, prev_data);
        end
      end
      prev_we   = bus.mem_we;
      prev_ack  = bus.mem_ack;
      prev_addr = bus.mem_addr;
      prev_data = bus.mem_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int            m_count;
    logic          stall_bad;
    logic [31:0]   wa;

    bus.rx_data    = 8'h00;
    bus.rx_changed = 1'b0;

    vecs[0] = '{word: 32'h12345678, exp_we: 1'b1, exp_count: 20'd1, exp_error: 1'b0, exp_loaded: 1'b0};
    vecs[1] = '{word: 32'hdeadbeef, exp_we: 1'b1, exp_count: 20'd2, exp_error: 1'b0, exp_loaded: 1'b0};
    vecs[2] = '{word: 32'hcafef00d, exp_we: 1'b0, exp_count: 20'd2, exp_error: 1'b1, exp_loaded: 1'b0};
    vecs[3] = '{word: 32'hffffffff, exp_we: 1'b0, exp_count: 20'd2, exp_error: 1'b1, exp_loaded: 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_mem_we",     32'(bus.mem_we),     32'd0);
    check("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
    check("rst_mem_wdata",  bus.mem_wdata,       32'd0);
    check("rst_loaded",     32'(bus.loaded),     32'd0);
    check("rst_word_count", 32'(bus.word_count), 32'd0);
    check("rst_error",      32'(bus.error),      32'd0);
    check("rst_fwd_valid",  32'(bus.fwd_valid),  32'd0);
    check("rst_fwd_data",   32'(bus.fwd_data),   32'd0);

    // Load with capacity overflow, then the end marker
    auto_ack = 1'b1;
    m_count  = 0;
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].word != 32'hffffffff) begin
        if (m_count < MAX) begin
          exp_wr.push_back('{addr: AW'(m_count), data: vecs[i].word});
          m_count++;
        end
      end
      send_word(vecs[i].word);
      check("vec_mem_we",     32'(bus.mem_we),     32'(vecs[i].exp_we));
      check("vec_word_count", 32'(bus.word_count), 32'(vecs[i].exp_count));
      check("vec_error",      32'(bus.error),      32'(vecs[i].exp_error));
      check("vec_loaded",     32'(bus.loaded),     32'(vecs[i].exp_loaded));
      if (vecs[i].exp_we) begin
        check("vec_mem_addr",  32'(bus.mem_addr), 32'(vecs[i].exp_count - 20'd1));
        check("vec_mem_wdata", bus.mem_wdata,     vecs[i].word);
      end
      wait_idle();
    end
    check("load_sb_empty", 32'(exp_wr.size()), 32'd0);

    // Pass-through
    for (int b = 1; b <= 4; b++) begin
      exp_fwd.push_back(8'(b));
      send_byte(8'(b));
      check("fwd_valid_pulse", 32'(bus.fwd_valid), 32'd1);
      check("fwd_data",        32'(bus.fwd_data),  32'(b));
      check("fwd_no_we",       32'(bus.mem_we),    32'd0);
      @(posedge clk); #1;
      check("fwd_valid_drop",  32'(bus.fwd_valid), 32'd0);
    end
    check("fwd_sb_empty", 32'(exp_fwd.size()), 32'd0);

    // Ack stall overrun, then marker while the write is pending
    auto_ack = 1'b0;
    bus.mem_ack = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("rst2_loaded", 32'(bus.loaded), 32'd0);
    check("rst2_error",  32'(bus.error),  32'd0);
    check("rst2_count",  32'(bus.word_count), 32'd0);
    wa = 32'h0badf00d;
    exp_wr.push_back('{addr: '0, data: wa});
    send_word(wa);
    check("stall_first_we", 32'(bus.mem_we), 32'd1);
    send_word(32'h5555aaaa);
    check("stall_error", 32'(bus.error),      32'd1);
    check("stall_count", 32'(bus.word_count), 32'd1);
    check("stall_wdata", bus.mem_wdata,       wa);
    stall_bad = 1'b0;
    repeat (200) begin
      @(posedge clk); #1;
      if (!bus.mem_we || bus.mem_wdata !== wa || bus.mem_addr !== '0) stall_bad = 1'b1;
    end
    check("stall_hold", 32'(stall_bad), 32'd0);
    send_word(32'hffffffff);
    check("drain_loaded_low", 32'(bus.loaded), 32'd0);
    check("drain_we_held",    32'(bus.mem_we), 32'd1);
    send_word(32'h22222222);
    check("drain_discard_count", 32'(bus.word_count), 32'd1);
    check("drain_discard_wdata", bus.mem_wdata,       wa);
    @(posedge clk); #1 bus.mem_ack = 1'b1;
    check("drain_loaded_at_ack", 32'(bus.loaded), 32'd0);
    @(posedge clk); #1 bus.mem_ack = 1'b0;
    check("drain_loaded_after_ack", 32'(bus.loaded),     32'd1);
    check("drain_we_retired",       32'(bus.mem_we),     32'd0);
    check("drain_count_final",      32'(bus.word_count), 32'd1);
    check("drain_sb_empty",         32'(exp_wr.size()),  32'd0);

    // Reset with a pending write and a partial word
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    send_word(32'h33333333);
    check("rstmid_we_before", 32'(bus.mem_we), 32'd1);
    send_byte(8'haa);
    send_byte(8'hbb);
    @(posedge clk); #3 reset = 1'b1;
    #1;
    check("rstmid_we_async", 32'(bus.mem_we),     32'd0);
    check("rstmid_count",    32'(bus.word_count), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    auto_ack = 1'b1;
    exp_wr.push_back('{addr: '0, data: 32'h89abcdef});
    send_word(32'h89abcdef);
    check("rstmid_addr",  32'(bus.mem_addr),   32'd0);
    check("rstmid_wdata", bus.mem_wdata,       32'h89abcdef);
    check("rstmid_count_after", 32'(bus.word_count), 32'd1);
    wait_idle();
    check("final_wr_sb_empty",  32'(exp_wr.size()),  32'd0);
    check("final_fwd_sb_empty", 32'(exp_fwd.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
